// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID-side inputs (operand selects, forwarding sources,
// decoded instruction) and the registered EX-side outputs.
interface id_ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic [1:0]        MUX_PA_E;
  logic [1:0]        MUX_PB_E;
  logic              CUMUX_E;
  logic              flush;
  logic [4:0]        ID_RS1;
  logic [4:0]        ID_RS2;
  logic [XLEN-1:0]   RF_PA;
  logic [XLEN-1:0]   RF_PB;
  logic [XLEN-1:0]   ALU_OUT;
  logic [XLEN-1:0]   MEM_OUT;
  logic [XLEN-1:0]   PW;
  logic [XLEN-1:0]   ID_PC;
  logic [XLEN-1:0]   ID_IMM;
  logic [CTRL_W-1:0] ID_CTRL;
  logic [4:0]        ID_RD;
  logic              ID_RF_E;
  logic              ID_LOAD;

  logic [XLEN-1:0]   EX_PA;
  logic [XLEN-1:0]   EX_PB;
  logic [XLEN-1:0]   EX_PC;
  logic [XLEN-1:0]   EX_IMM;
  logic [CTRL_W-1:0] EX_CTRL;
  logic [4:0]        RD_EX;
  logic              EX_RF_E;
  logic              load_instr;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output MUX_PA_E, MUX_PB_E, CUMUX_E, flush, ID_RS1, ID_RS2,
           RF_PA, RF_PB, ALU_OUT, MEM_OUT, PW, ID_PC, ID_IMM,
           ID_CTRL, ID_RD, ID_RF_E, ID_LOAD,
    input  EX_PA, EX_PB, EX_PC, EX_IMM, EX_CTRL, RD_EX, EX_RF_E,
           load_instr, bubble_count
  );

  modport slave (
    input  MUX_PA_E, MUX_PB_E, CUMUX_E, flush, ID_RS1, ID_RS2,
           RF_PA, RF_PB, ALU_OUT, MEM_OUT, PW, ID_PC, ID_IMM,
           ID_CTRL, ID_RD, ID_RF_E, ID_LOAD,
    output EX_PA, EX_PB, EX_PC, EX_IMM, EX_CTRL, RD_EX, EX_RF_E,
           load_instr, bubble_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: forwarding-mux operand select, bubble insertion on
// load-use stall or flush, and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  id_ex_operand_stage_if.slave bus
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            bubble;

  // x0 must read as zero: the hazard unit may request forwarding for rs=0.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (bus.MUX_PA_E)
      2'b00:   op_a = bus.RF_PA;
      2'b01:   op_a = bus.ALU_OUT;
      2'b10:   op_a = bus.MEM_OUT;
      default: op_a = bus.PW;
    endcase
    case (bus.MUX_PB_E)
      2'b00:   op_b = bus.RF_PB;
      2'b01:   op_b = bus.ALU_OUT;
      2'b10:   op_b = bus.MEM_OUT;
      default: op_b = bus.PW;
    endcase
    if (bus.ID_RS1 == 5'd0) op_a = '0;
    if (bus.ID_RS2 == 5'd0) op_b = '0;
  end

  assign bubble = bus.flush | bus.CUMUX_E;

  // A bubble zeroes the whole stage; the stalled instruction is recaptured later.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.EX_PA      <= '0;
      bus.EX_PB      <= '0;
      bus.EX_PC      <= '0;
      bus.EX_IMM     <= '0;
      bus.EX_CTRL    <= '0;
      bus.RD_EX      <= '0;
      bus.EX_RF_E    <= 1'b0;
      bus.load_instr <= 1'b0;
    end else begin
      bus.EX_PA      <= op_a;
      bus.EX_PB      <= op_b;
      bus.EX_PC      <= bus.ID_PC;
      bus.EX_IMM     <= bus.ID_IMM;
      bus.EX_CTRL    <= bus.ID_CTRL;
      bus.RD_EX      <= bus.ID_RD;
      bus.EX_RF_E    <= bus.ID_RF_E & (bus.ID_RD != 5'd0);
      bus.load_instr <= bus.ID_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bubble_count <= '0;
    end else if (bubble && (bus.bubble_count != {CNT_W{1'b1}})) begin
      bus.bubble_count <= bus.bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed steps plus random
// traffic checked against a behavioural model; built with CNT_W=4.
module tb_id_ex_operand_stage;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  id_ex_operand_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_pa, exp_pb, exp_pc, exp_imm, exp_ctrl, exp_rd, exp_rfe, exp_load;
  int          model_bubbles = 0;
  logic [31:0] saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Randomize every input; bubbles only when allowed.
  task automatic applyStimulus(input bit allow_bubble);
    bus.MUX_PA_E = 2'($urandom);
    bus.MUX_PB_E = 2'($urandom);
    bus.CUMUX_E  = allow_bubble ? ($urandom_range(0, 3) == 0) : 1'b0;
    bus.flush    = allow_bubble ? ($urandom_range(0, 5) == 0) : 1'b0;
    bus.ID_RS1   = 5'($urandom);
    bus.ID_RS2   = 5'($urandom);
    bus.RF_PA    = $urandom;
    bus.RF_PB    = $urandom;
    bus.ALU_OUT  = $urandom;
    bus.MEM_OUT  = $urandom;
    bus.PW       = $urandom;
    bus.ID_PC    = $urandom;
    bus.ID_IMM   = $urandom;
    bus.ID_CTRL  = 16'($urandom);
    bus.ID_RD    = 5'($urandom);
    bus.ID_RF_E  = 1'($urandom);
    bus.ID_LOAD  = 1'($urandom);
  endtask

  // Reference model: what the stage must hold after the coming edge.
  task automatic computeExpected();
    logic [31:0] src_a [4];
    logic [31:0] src_b [4];
    src_a = '{bus.RF_PA, bus.ALU_OUT, bus.MEM_OUT, bus.PW};
    src_b = '{bus.RF_PB, bus.ALU_OUT, bus.MEM_OUT, bus.PW};
    if (reset || bus.flush || bus.CUMUX_E) begin
      {exp_pa, exp_pb, exp_pc, exp_imm} = '0;
      {exp_ctrl, exp_rd, exp_rfe, exp_load} = '0;
      if (reset) model_bubbles = 0;
      else model_bubbles++;
    end else begin
      exp_pa   = (bus.ID_RS1 == 0) ? 32'd0 : src_a[bus.MUX_PA_E];
      exp_pb   = (bus.ID_RS2 == 0) ? 32'd0 : src_b[bus.MUX_PB_E];
      exp_pc   = bus.ID_PC;
      exp_imm  = bus.ID_IMM;
      exp_ctrl = 32'(bus.ID_CTRL);
      exp_rd   = 32'(bus.ID_RD);
      exp_rfe  = 32'(bus.ID_RF_E && bus.ID_RD != 0);
      exp_load = 32'(bus.ID_LOAD);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".EX_PA"},   bus.EX_PA, exp_pa);
    chk({tag, ".EX_PB"},   bus.EX_PB, exp_pb);
    chk({tag, ".EX_PC"},   bus.EX_PC, exp_pc);
    chk({tag, ".EX_IMM"},  bus.EX_IMM, exp_imm);
    chk({tag, ".EX_CTRL"}, 32'(bus.EX_CTRL), exp_ctrl);
    chk({tag, ".RD_EX"},   32'(bus.RD_EX), exp_rd);
    chk({tag, ".EX_RF_E"}, 32'(bus.EX_RF_E), exp_rfe);
    chk({tag, ".load"},    32'(bus.load_instr), exp_load);
    chk({tag, ".bubbles"}, 32'(bus.bubble_count),
        32'((model_bubbles > CNT_MAX) ? CNT_MAX : model_bubbles));
  endtask

  // One clock: predict, take the edge, sample 1 ns later, return to negedge.
  task automatic cycle(input string tag);
    computeExpected();
    @(posedge clk);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1);
    @(negedge clk);

    // Reset with random inputs.
    applyStimulus(1'b1); cycle("reset1");
    applyStimulus(1'b1); cycle("reset2");
    chk("reset.count", 32'(bus.bubble_count), 32'd0);
    chk("reset.pa", bus.EX_PA, 32'd0);

    // First capture after release.
    reset = 1'b0;
    applyStimulus(1'b0);
    bus.ID_RS1 = 5'd1; bus.ID_RS2 = 5'd2;
    bus.ID_RD = 5'd5; bus.ID_RF_E = 1'b1;
    bus.MUX_PA_E = 2'b00; bus.MUX_PB_E = 2'b00;
    bus.RF_PA = 32'h11; bus.RF_PB = 32'h22;
    cycle("release");
    chk("release.pa", bus.EX_PA, 32'h11);
    chk("release.pb", bus.EX_PB, 32'h22);
    chk("release.rd", 32'(bus.RD_EX), 32'd5);
    chk("release.rfe", 32'(bus.EX_RF_E), 32'd1);

    // Forwarding mux sweep.
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(1'b0);
      bus.ID_RS1 = 5'd3; bus.ID_RS2 = 5'd4;
      bus.ALU_OUT = 32'hA; bus.MEM_OUT = 32'hB; bus.PW = 32'hC;
      bus.MUX_PA_E = 2'(s); bus.MUX_PB_E = 2'b10;
      cycle("fwd");
      chk("fwd.pa", bus.EX_PA, 32'h9 + 32'(s));
      chk("fwd.pb", bus.EX_PB, 32'hB);
    end

    // x0 rules.
    applyStimulus(1'b0);
    bus.ID_RS1 = 5'd0; bus.MUX_PA_E = 2'b01; bus.ALU_OUT = 32'hDEAD;
    bus.ID_RD = 5'd0; bus.ID_RF_E = 1'b1;
    cycle("x0");
    chk("x0.pa", bus.EX_PA, 32'd0);
    chk("x0.rfe", 32'(bus.EX_RF_E), 32'd0);

    // Load-use stall then recapture with MEM forwarding.
    applyStimulus(1'b0);
    bus.ID_LOAD = 1'b1; bus.ID_RD = 5'd7; bus.ID_RF_E = 1'b1;
    cycle("load");
    chk("load.flag", 32'(bus.load_instr), 32'd1);
    applyStimulus(1'b0);
    bus.CUMUX_E = 1'b1;
    cycle("stall");
    chk("stall.ctrl", 32'(bus.EX_CTRL), 32'd0);
    chk("stall.rd", 32'(bus.RD_EX), 32'd0);
    chk("stall.load", 32'(bus.load_instr), 32'd0);
    chk("stall.count", 32'(bus.bubble_count), 32'd1);
    applyStimulus(1'b0);
    bus.ID_RS1 = 5'd7; bus.MUX_PA_E = 2'b10;
    saved = bus.MEM_OUT;
    cycle("recap");
    chk("recap.pa", bus.EX_PA, saved);

    // Flush and stall together count as one bubble.
    applyStimulus(1'b0);
    bus.flush = 1'b1; bus.CUMUX_E = 1'b1;
    cycle("flushstall");
    chk("flushstall.count", 32'(bus.bubble_count), 32'd2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1);
      reset = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    // Saturation: 2^CNT_W+3 bubbles from a cleared counter.
    reset = 1'b1; applyStimulus(1'b0); cycle("satreset");
    reset = 1'b0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      applyStimulus(1'b1);
      bus.CUMUX_E = 1'b1;
      cycle("sat");
    end
    chk("sat.count", 32'(bus.bubble_count), 32'hF);

    // Reset during a stall clears everything in that cycle.
    applyStimulus(1'b0);
    bus.CUMUX_E = 1'b1; bus.flush = 1'b1; reset = 1'b1;
    cycle("resetstall");
    chk("resetstall.count", 32'(bus.bubble_count), 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the RISC-V PPU.
- Selects each source operand from the register file or a forwarding source, using the select codes produced by the hazard/forwarding unit, and registers the operands with the decoded control bundle into EX.
- Inserts a bubble when the hazard unit requests a load-use stall or when a control transfer flushes ID.
- Returns RD_EX, EX_RF_E and load_instr to the hazard/forwarding unit.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of the opaque decoded control bundle.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MUX_PA_E  in  2  operand A select: 00 RF, 01 ALU, 10 MEM, 11 PW.
- MUX_PB_E  in  2  operand B select, same encoding as MUX_PA_E.
- CUMUX_E  in  1  load-use stall: insert a bubble.
- flush  in  1  taken branch/jump in EX: squash the ID instruction.
- ID_RS1  in  5  source register 1 of the ID instruction.
- ID_RS2  in  5  source register 2 of the ID instruction.
- RF_PA  in  XLEN  register-file port A.
- RF_PB  in  XLEN  register-file port B.
- ALU_OUT  in  XLEN  EX-stage ALU result.
- MEM_OUT  in  XLEN  MEM-stage result mux.
- PW  in  XLEN  WB write data.
- ID_PC  in  XLEN  PC of the ID instruction.
- ID_IMM  in  XLEN  immediate of the ID instruction.
- ID_CTRL  in  CTRL_W  decoded control bundle.
- ID_RD  in  5  destination register.
- ID_RF_E  in  1  instruction writes the register file.
- ID_LOAD  in  1  instruction is a load.
- EX_PA  out  XLEN  registered operand A.
- EX_PB  out  XLEN  registered operand B.
- EX_PC  out  XLEN  registered PC.
- EX_IMM  out  XLEN  registered immediate.
- EX_CTRL  out  CTRL_W  registered control bundle.
- RD_EX  out  5  registered destination register.
- EX_RF_E  out  1  registered write enable.
- load_instr  out  1  registered load flag; goes to the hazard unit.
- bubble_count  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset, on a clocked edge with reset=1: every output is 0, including bubble_count. reset has priority over every other input. A reset in the middle of a stall or flush clears all state in that cycle.
- Operand select (combinational, before the register):
  - opA = RF_PA, ALU_OUT, MEM_OUT or PW for MUX_PA_E = 00, 01, 10, 11.
  - opB is selected the same way from MUX_PB_E.
- x0 rule: if ID_RS1 = 0, opA = 0 whatever MUX_PA_E says. If ID_RS2 = 0, opB = 0 likewise. This is needed because the hazard unit does not exclude x0 when it compares register numbers.
- Normal capture, when reset=0, flush=0 and CUMUX_E=0:
  - All EX_* outputs take their ID values (opA, opB, ID_PC, ID_IMM, ID_CTRL, ID_RD, ID_LOAD).
  - EX_RF_E = ID_RF_E AND (ID_RD != 0).
  - Latency is 1 cycle.
- Bubble, when flush=1 or CUMUX_E=1:
  - EX_CTRL, RD_EX, EX_RF_E, load_instr, EX_PA, EX_PB, EX_IMM and EX_PC are all loaded with 0.
  - The stage never holds its contents. On a load-use stall the ID instruction stays in IF/ID, because the hazard unit drops PC_E/IF_ID_E, and it is recaptured on a later cycle.
- Simultaneous flush and CUMUX_E: one bubble is inserted and bubble_count increments by 1 only.
- bubble_count:
  - Increments by 1 on every bubble cycle.
  - Saturates at all-ones; it does not wrap.
  - Cleared only by reset.
- Back-to-back stalls: each stalled cycle inserts a bubble and increments the counter.
- Forwarding sources are sampled in the same cycle as the capture. There is no internal storage of ALU_OUT, MEM_OUT or PW.

Test Plan:
- Reset: hold reset=1 for 2 cycles with random inputs -> every output 0 and bubble_count=0. Release reset with ID_RD=5, ID_RF_E=1, selects 00, RF_PA=0x11, RF_PB=0x22 -> one cycle later EX_PA=0x11, EX_PB=0x22, RD_EX=5, EX_RF_E=1.
- Forward mux: ID_RS1=3, ID_RS2=4, ALU_OUT=0xA, MEM_OUT=0xB, PW=0xC. Step MUX_PA_E through 01, 10, 11 with MUX_PB_E=10 -> EX_PA = 0xA, 0xB, 0xC in turn, EX_PB=0xB each cycle.
- x0: ID_RS1=0 with MUX_PA_E=01 and ALU_OUT=0xDEAD -> EX_PA=0. ID_RD=0 with ID_RF_E=1 -> EX_RF_E=0.
- Load-use stall: a load with ID_LOAD=1 and ID_RD=7 is captured, then CUMUX_E=1 for 1 cycle -> next cycle EX_CTRL=0, RD_EX=0, load_instr=0, bubble_count=1. When the following instruction is recaptured with MUX_PA_E=10, EX_PA equals MEM_OUT.
- Flush together with stall: flush=1 and CUMUX_E=1 in the same cycle -> one bubble, bubble_count increments by exactly 1.
- Saturation: force 2^CNT_W+3 bubble cycles (use CNT_W=4 in a test build) -> bubble_count holds at 0xF.
